// File: rtl/csa_tree_adder_pipe.sv
// csa_tree_adder_pipe
//
// Pipelined multi-operand adder. NUM_IN operands of WIDTH bits are extended
// to OUT_W bits (zero- or sign-extended per SIGNED). They are reduced by a
// tree of registered 3:2 carry-save levels down to two rows. A final
// registered carry-propagate add follows. Every stage carries a valid bit.
// A stage advances when it is empty or when its downstream stage advances,
// so bubbles collapse and backpressure ripples combinationally to in_ready.
//
// Parameters:
//   WIDTH   operand width (>= 1)
//   NUM_IN  operand count (2..16)
//   SIGNED  0 = unsigned operands, 1 = two's complement operands
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valids and data)
//   in_valid   operand set present on in_data
//   in_ready   operand set accepted this cycle when in_valid is also high
//   in_data    packed operands, operand i = in_data[i*WIDTH +: WIDTH]
//   out_valid  out_data holds a result
//   out_ready  consumer takes the result this cycle
//   out_data   OUT_W-bit sum of all operands of one set

module csa_tree_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SIGNED = 0,
    localparam int OUT_W = WIDTH + $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data
);

    // Row count entering 3:2 level lvl; a level turns each full group of
    // three rows into two and passes leftover rows through untouched.
    function automatic int rows_at(input int lvl);
        int r;
        r = NUM_IN;
        for (int i = 0; i < lvl; i++) begin
            if (r > 2) begin
                r = (r / 3) * 2 + (r % 3);
            end
        end
        return r;
    endfunction

    function automatic int num_levels();
        int r;
        int n;
        r = NUM_IN;
        n = 0;
        while (r > 2) begin
            r = (r / 3) * 2 + (r % 3);
            n++;
        end
        return n;
    endfunction

    localparam int LEVELS  = num_levels();
    localparam int LATENCY = LEVELS + 1;

    // Stage handshake: stage s holds v_q[s]; adv[s] means it loads this cycle.
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] v_d;
    logic [LATENCY-1:0] adv;
    logic [LATENCY-1:0] up_v;
    logic [LATENCY-1:0] load_v;

    always_comb begin
        logic chain;
        adv    = '0;
        up_v   = '0;
        load_v = '0;
        v_d    = v_q;
        chain  = out_ready || !v_q[LATENCY-1];
        adv[LATENCY-1] = chain;
        for (int s = LATENCY - 2; s >= 0; s--) begin
            chain  = !v_q[s] || chain;
            adv[s] = chain;
        end
        up_v[0] = in_valid;
        for (int s = 1; s < LATENCY; s++) begin
            up_v[s] = v_q[s-1];
        end
        for (int s = 0; s < LATENCY; s++) begin
            // Data only loads when real data arrives, so X on an idle
            // in_data never reaches the registers.
            load_v[s] = adv[s] && up_v[s];
            if (adv[s]) begin
                v_d[s] = up_v[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[LATENCY-1];

    // Operand extension to OUT_W bits.
    logic        [OUT_W-1:0] ext [NUM_IN];
    logic signed [WIDTH-1:0] op_s;

    always_comb begin
        op_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            op_s = in_data[i*WIDTH +: WIDTH];
            if (SIGNED != 0) begin
                ext[i] = OUT_W'(op_s);
            end else begin
                ext[i] = OUT_W'(unsigned'(op_s));
            end
        end
    end

    // 3:2 carry-save levels, one register stage each.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int RIN  = rows_at(l);
        localparam int ROUT = rows_at(l + 1);
        localparam int NG   = RIN / 3;

        logic [OUT_W-1:0] src   [RIN];
        logic [OUT_W-1:0] row_d [ROUT];
        logic [OUT_W-1:0] row_q [ROUT];

        if (l == 0) begin : g_src_in
            assign src = ext;
        end else begin : g_src_prev
            assign src = g_lvl[l-1].row_q;
        end

        always_comb begin
            for (int r = 0; r < ROUT; r++) begin
                row_d[r] = row_q[r];
            end
            if (load_v[l]) begin
                for (int g = 0; g < NG; g++) begin
                    row_d[2*g] = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
                    // Carry row moves up one bit; the bit shifted past
                    // OUT_W is dropped, which is exact modulo 2^OUT_W.
                    row_d[2*g+1] = ((src[3*g] & src[3*g+1]) |
                                    (src[3*g] & src[3*g+2]) |
                                    (src[3*g+1] & src[3*g+2])) << 1;
                end
                for (int k = 0; k < RIN - 3*NG; k++) begin
                    row_d[2*NG+k] = src[3*NG+k];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int r = 0; r < ROUT; r++) begin
                    row_q[r] <= '0;
                end
            end else begin
                for (int r = 0; r < ROUT; r++) begin
                    row_q[r] <= row_d[r];
                end
            end
        end
    end

    // Final carry-propagate add stage.
    logic [OUT_W-1:0] fin_a;
    logic [OUT_W-1:0] fin_b;
    logic [OUT_W-1:0] sum_d;
    logic [OUT_W-1:0] sum_q;

    if (LEVELS == 0) begin : g_fin_direct
        assign fin_a = ext[0];
        assign fin_b = ext[1];
    end else begin : g_fin_tree
        assign fin_a = g_lvl[LEVELS-1].row_q[0];
        assign fin_b = g_lvl[LEVELS-1].row_q[1];
    end

    always_comb begin
        sum_d = sum_q;
        if (load_v[LATENCY-1]) begin
            sum_d = fin_a + fin_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_data = sum_q;

endmodule

// File: tb/tb_csa_tree_adder_pipe.sv
// tb_csa_tree_adder_pipe
//
// Bench for csa_tree_adder_pipe. Four instances run side by side:
//   a: WIDTH=8,  NUM_IN=3, unsigned  (LATENCY 2)
//   b: WIDTH=8,  NUM_IN=4, signed    (LATENCY 3)
//   c: WIDTH=16, NUM_IN=9, unsigned  (LATENCY 5) streaming / stall / reset
//   d: WIDTH=32, NUM_IN=2, unsigned  (LATENCY 1)

module tb_csa_tree_adder_pipe;

    localparam int LAT_C = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [23:0] in_data_a;
    logic [9:0]  out_data_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [31:0] in_data_b;
    logic [9:0]  out_data_b;

    logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c;
    logic [143:0] in_data_c;
    logic [19:0]  out_data_c;

    logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d;
    logic [63:0] in_data_d;
    logic [32:0] out_data_d;

    csa_tree_adder_pipe #(.WIDTH(8), .NUM_IN(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a));

    csa_tree_adder_pipe #(.WIDTH(8), .NUM_IN(4), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b));

    csa_tree_adder_pipe #(.WIDTH(16), .NUM_IN(9), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_data(out_data_c));

    csa_tree_adder_pipe #(.WIDTH(32), .NUM_IN(2), .SIGNED(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .in_data(in_data_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
        .out_data(out_data_d));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] sum9(input logic [143:0] d);
        logic [19:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + 20'(d[i*16 +: 16]);
        end
        return s;
    endfunction

    function automatic logic [143:0] rand9();
        logic [143:0] d;
        for (int i = 0; i < 9; i++) begin
            d[i*16 +: 16] = 16'($urandom);
        end
        return d;
    endfunction

    logic [19:0]  exp_q[$];
    logic [19:0]  exp1 [20];
    logic [143:0] one_set;
    logic         stalled_prev;
    logic [19:0]  held;
    int           n;
    int           extra;

    initial begin
        rst_n = 1'b0;
        in_valid_a = 0; in_valid_b = 0; in_valid_c = 0; in_valid_d = 0;
        out_ready_a = 1; out_ready_b = 1; out_ready_c = 1; out_ready_d = 1;
        in_data_a = '0; in_data_b = '0; in_data_c = '0; in_data_d = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_vld_a", 64'(out_valid_a), 64'd0);
        chk("rst_dat_a", 64'(out_data_a), 64'd0);
        chk("rst_vld_b", 64'(out_valid_b), 64'd0);
        chk("rst_vld_c", 64'(out_valid_c), 64'd0);
        chk("rst_dat_c", 64'(out_data_c), 64'd0);
        chk("rst_vld_d", 64'(out_valid_d), 64'd0);
        chk("rst_rdy_c", 64'(in_ready_c), 64'd1);
        rst_n = 1'b1;

        // Directed vectors on a, b, d; accepted in the first cycle after release
        in_valid_a = 1; in_data_a = {8'd255, 8'd255, 8'd255};
        in_valid_b = 1; in_data_b = {8'h80, 8'h80, 8'h80, 8'h80};
        in_valid_d = 1; in_data_d = {32'd1, 32'hFFFF_FFFF};
        #1;
        chk("rdy_a_first", 64'(in_ready_a), 64'd1);
        tick();
        chk("d_vld_lat1", 64'(out_valid_d), 64'd1);
        chk("d_dat_carry", 64'(out_data_d), 64'h1_0000_0000);
        chk("a_vld_early", 64'(out_valid_a), 64'd0);
        in_valid_a = 0; in_valid_d = 0;
        in_data_b = {8'd1, 8'd0, 8'hFF, 8'd127};
        tick();
        chk("a_vld_lat2", 64'(out_valid_a), 64'd1);
        chk("a_dat_765", 64'(out_data_a), 64'd765);
        chk("d_vld_drop", 64'(out_valid_d), 64'd0);
        chk("b_vld_early", 64'(out_valid_b), 64'd0);
        in_valid_b = 0;
        tick();
        chk("a_vld_drop", 64'(out_valid_a), 64'd0);
        chk("b_vld_lat3", 64'(out_valid_b), 64'd1);
        chk("b_dat_neg512", 64'(out_data_b), 64'h200);
        tick();
        chk("b_vld_2nd", 64'(out_valid_b), 64'd1);
        chk("b_dat_127", 64'(out_data_b), 64'd127);
        tick();
        chk("b_vld_drop", 64'(out_valid_b), 64'd0);

        // c: back-to-back stream, one result per cycle after LAT_C
        for (int c = 0; c < 20 + LAT_C; c++) begin
            if (c < 20) begin
                in_valid_c = 1;
                in_data_c  = rand9();
                exp1[c]    = sum9(in_data_c);
            end else begin
                in_valid_c = 0;
                in_data_c  = 'x;
            end
            #1;
            if (c < 20) chk("c_stream_rdy", 64'(in_ready_c), 64'd1);
            tick();
            if (c >= LAT_C - 1 && c - (LAT_C - 1) < 20) begin
                chk("c_stream_vld", 64'(out_valid_c), 64'd1);
                chk("c_stream_dat", 64'(out_data_c), 64'(exp1[c - (LAT_C - 1)]));
            end
        end
        tick();
        chk("c_stream_idle", 64'(out_valid_c), 64'd0);

        // c: random gaps and backpressure against an in-order scoreboard
        stalled_prev = 0;
        held = '0;
        for (int it = 0; it < 300; it++) begin
            in_valid_c = ($urandom_range(0, 3) != 0);
            if (in_valid_c) in_data_c = rand9();
            else            in_data_c = 'x;
            out_ready_c = ($urandom_range(0, 1) != 0);
            #1;
            chk("c_rdy_rule", 64'(in_ready_c),
                64'(!(exp_q.size() == LAT_C && !out_ready_c)));
            if (stalled_prev) begin
                chk("c_stall_vld", 64'(out_valid_c), 64'd1);
                chk("c_stall_dat", 64'(out_data_c), 64'(held));
            end
            if (out_valid_c && out_ready_c) begin
                chk("c_out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("c_order_dat", 64'(out_data_c), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid_c && in_ready_c) exp_q.push_back(sum9(in_data_c));
            stalled_prev = out_valid_c && !out_ready_c;
            held = out_data_c;
            tick();
        end
        in_valid_c = 0;
        in_data_c  = 'x;
        out_ready_c = 1;
        for (int it = 0; it < 40 && exp_q.size() != 0; it++) begin
            #1;
            if (out_valid_c) begin
                chk("c_drain_dat", 64'(out_data_c), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            tick();
        end
        chk("c_drain_empty", 64'(exp_q.size()), 64'd0);
        chk("c_drain_vld", 64'(out_valid_c), 64'd0);

        // c: reset with three results in flight
        out_ready_c = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid_c = 1;
            in_data_c  = rand9();
            tick();
        end
        in_valid_c = 0;
        in_data_c  = 'x;
        repeat (3) tick();
        chk("c_inflight_vld", 64'(out_valid_c), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("c_arst_vld", 64'(out_valid_c), 64'd0);
        chk("c_arst_dat", 64'(out_data_c), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready_c = 1;
        in_valid_c = 1;
        one_set = rand9();
        in_data_c = one_set;
        tick();
        in_valid_c = 0;
        in_data_c = 'x;
        n = 1;
        while (!out_valid_c && n < 12) begin
            tick();
            n++;
        end
        chk("c_post_rst_lat", 64'(n), 64'(LAT_C));
        chk("c_post_rst_dat", 64'(out_data_c), 64'(sum9(one_set)));
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid_c) extra++;
        end
        chk("c_post_rst_only", 64'(extra), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
